// File: rtl/kmc_npr_responder.sv
// kmc_npr_responder: memory-side responder for KMC11 NPR (DMA) requests.
// Runs one word/byte memory cycle per device request; a memory cycle that
// times out pulses nxmERR and withholds devACKO so the requester sees NXM.
module kmc_npr_responder #(
  parameter int unsigned TIMEOUT = 100,
  parameter int unsigned AW      = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          devREQI,
  input  logic          devWRI,
  input  logic          devBYTEI,
  input  logic [AW-1:0] devADDRI,
  input  logic [15:0]   devDATAI,
  output logic          devACKO,
  output logic [15:0]   devDATAO,
  output logic          memREQO,
  output logic          memWRO,
  output logic [AW-1:0] memADDRO,
  output logic [1:0]    memBEO,
  output logic [15:0]   memDATAO,
  input  logic [15:0]   memDATAI,
  input  logic          memACKI,
  output logic          nxmERR,
  output logic          busy
);

  localparam logic [11:0] TMO = 12'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, MEM, ACK, REL} state_t;

  state_t        state, state_d;
  logic [11:0]   timer, timer_d;
  logic          acko_d, req_d, wr_d, nxm_d;
  logic [AW-1:0] addr_d;
  logic [1:0]    be_d;
  logic [15:0]   wdata_d, rdata_d;

  assign busy = (state != IDLE);

  // Every output is registered; this block only computes next values.
  always_comb begin
    state_d = state;
    timer_d = timer;
    acko_d  = devACKO;
    req_d   = memREQO;
    wr_d    = memWRO;
    addr_d  = memADDRO;
    be_d    = memBEO;
    wdata_d = memDATAO;
    rdata_d = devDATAO;
    nxm_d   = nxmERR;
    case (state)
      IDLE: begin
        if (devREQI) begin
          req_d   = 1'b1;
          wr_d    = devWRI;
          addr_d  = {devADDRI[AW-1:1], 1'b0};
          be_d    = devBYTEI ? (devADDRI[0] ? 2'b10 : 2'b01) : 2'b11;
          wdata_d = devDATAI;
          timer_d = TMO;
          state_d = MEM;
        end
      end
      MEM: begin
        if (memACKI) begin
          req_d   = 1'b0;
          wr_d    = 1'b0;
          if (!memWRO) rdata_d = memDATAI;
          acko_d  = 1'b1;
          state_d = ACK;
        end else if (timer != '0) begin
          timer_d = timer - 12'd1;
        end else begin
          req_d   = 1'b0;
          wr_d    = 1'b0;
          nxm_d   = 1'b1;
          state_d = REL;
        end
      end
      ACK: begin
        acko_d  = 1'b0;
        state_d = REL;
      end
      REL: begin
        nxm_d = 1'b0;
        if (!devREQI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any cycle in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      timer    <= TMO;
      devACKO  <= 1'b0;
      devDATAO <= '0;
      memREQO  <= 1'b0;
      memWRO   <= 1'b0;
      memADDRO <= '0;
      memBEO   <= '0;
      memDATAO <= '0;
      nxmERR   <= 1'b0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      devACKO  <= acko_d;
      devDATAO <= rdata_d;
      memREQO  <= req_d;
      memWRO   <= wr_d;
      memADDRO <= addr_d;
      memBEO   <= be_d;
      memDATAO <= wdata_d;
      nxmERR   <= nxm_d;
    end
  end

endmodule

// File: tb/tb_kmc_npr_responder.sv
// Directed bench for kmc_npr_responder with TIMEOUT=10.
module tb_kmc_npr_responder;

  localparam int unsigned TMO = 10;
  localparam int unsigned AW  = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          devREQI, devWRI, devBYTEI;
  logic [AW-1:0] devADDRI;
  logic [15:0]   devDATAI;
  logic          devACKO;
  logic [15:0]   devDATAO;
  logic          memREQO, memWRO;
  logic [AW-1:0] memADDRO;
  logic [1:0]    memBEO;
  logic [15:0]   memDATAO;
  logic [15:0]   memDATAI;
  logic          memACKI;
  logic          nxmERR;
  logic          busy;

  always #5 clk = ~clk;

  kmc_npr_responder #(.TIMEOUT(TMO), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .devREQI(devREQI), .devWRI(devWRI), .devBYTEI(devBYTEI),
    .devADDRI(devADDRI), .devDATAI(devDATAI),
    .devACKO(devACKO), .devDATAO(devDATAO),
    .memREQO(memREQO), .memWRO(memWRO), .memADDRO(memADDRO),
    .memBEO(memBEO), .memDATAO(memDATAO), .memDATAI(memDATAI),
    .memACKI(memACKI), .nxmERR(nxmERR), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty: observed=%0h expected=<queued value>", obs);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic wr, input logic byt,
                         input logic [AW-1:0] addr, input logic [15:0] data);
    devWRI   = wr;
    devBYTEI = byt;
    devADDRI = addr;
    devDATAI = data;
    devREQI  = 1'b1;
  endtask

  int n;
  int req_seen;
  bit ack_seen;

  initial begin
    rst = 1'b0; devREQI = 1'b0; devWRI = 1'b0; devBYTEI = 1'b0;
    devADDRI = '0; devDATAI = '0; memDATAI = '0; memACKI = 1'b0;
    tick(); tick();
    check("rst_memREQO", 32'(memREQO), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_devACKO", 32'(devACKO), 32'd0);
    check("rst_devDATAO",32'(devDATAO),32'd0);
    check("rst_nxmERR",  32'(nxmERR),  32'd0);
    rst = 1'b1;
    tick();

    // 1: word write, ack after 3 clocks
    request(1'b1, 1'b0, 18'o1000, 16'hBEEF);
    push("t1_memBEO", 32'h3);
    push("t1_memADDRO", 32'o1000);
    push("t1_memDATAO", 32'hBEEF);
    push("t1_memWRO", 32'd1);
    tick();
    check("t1_req_latency", 32'(memREQO), 32'd1);
    pop_check(32'(memBEO));
    pop_check(32'(memADDRO));
    pop_check(32'(memDATAO));
    pop_check(32'(memWRO));
    tick(); tick();
    check("t1_req_held", 32'(memREQO), 32'd1);
    memACKI = 1'b1;
    tick();
    memACKI = 1'b0;
    check("t1_devACKO", 32'(devACKO), 32'd1);
    check("t1_req_drop", 32'(memREQO), 32'd0);
    tick();
    check("t1_ack_width", 32'(devACKO), 32'd0);
    check("t1_busy_rel", 32'(busy), 32'd1);
    devREQI = 1'b0;
    tick();
    check("t1_idle", 32'(busy), 32'd0);

    // 2: byte read at odd address
    request(1'b0, 1'b1, 18'o1001, 16'h0000);
    push("t2_memBEO", 32'h2);
    push("t2_memADDRO", 32'o1000);
    push("t2_memWRO", 32'd0);
    tick();
    pop_check(32'(memBEO));
    pop_check(32'(memADDRO));
    pop_check(32'(memWRO));
    memDATAI = 16'h12AB;
    memACKI  = 1'b1;
    push("t2_devDATAO", 32'h12AB);
    push("t2_devDATAO_held", 32'h12AB);
    tick();
    memACKI  = 1'b0;
    memDATAI = 16'h0000;
    check("t2_devACKO", 32'(devACKO), 32'd1);
    pop_check(32'(devDATAO));
    tick();
    devREQI = 1'b0;
    tick();
    pop_check(32'(devDATAO));

    // 3: timeout with no memACKI
    request(1'b0, 1'b0, 18'o2000, 16'h0000);
    tick();
    check("t3_req", 32'(memREQO), 32'd1);
    n = 0;
    ack_seen = 1'b0;
    do begin
      tick();
      n++;
      if (devACKO === 1'b1) ack_seen = 1'b1;
    end while (memREQO === 1'b1 && n < 50);
    check("t3_timeout_clocks", 32'(n), 32'(TMO + 1));
    check("t3_nxmERR", 32'(nxmERR), 32'd1);
    check("t3_no_ack", 32'(ack_seen), 32'd0);
    tick();
    check("t3_nxm_width", 32'(nxmERR), 32'd0);
    tick(); tick();
    check("t3_busy_held", 32'(busy), 32'd1);
    check("t3_no_ack_late", 32'(devACKO), 32'd0);
    devREQI = 1'b0;
    tick();
    check("t3_idle", 32'(busy), 32'd0);

    // 4: memACKI in the timer==0 cycle wins over expiry
    request(1'b1, 1'b0, 18'o3000, 16'h5555);
    tick();
    for (int i = 0; i < int'(TMO); i++) tick();
    check("t4_req_still", 32'(memREQO), 32'd1);
    memACKI = 1'b1;
    tick();
    memACKI = 1'b0;
    check("t4_devACKO", 32'(devACKO), 32'd1);
    check("t4_nxm0", 32'(nxmERR), 32'd0);
    tick();
    check("t4_nxm1", 32'(nxmERR), 32'd0);
    devREQI = 1'b0;
    tick();

    // 5: held devREQI starts only one cycle
    request(1'b0, 1'b0, 18'o4000, 16'h0000);
    tick();
    memACKI = 1'b1;
    tick();
    memACKI = 1'b0;
    check("t5_devACKO", 32'(devACKO), 32'd1);
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (memREQO === 1'b1) req_seen++;
    end
    check("t5_no_second_req", 32'(req_seen), 32'd0);
    devREQI = 1'b0;
    tick();
    devREQI = 1'b1;
    tick();
    check("t5_second_req", 32'(memREQO), 32'd1);
    memACKI = 1'b1;
    tick();
    memACKI = 1'b0;
    devREQI = 1'b0;
    tick(); tick();

    // 6: asynchronous reset during MEM
    request(1'b1, 1'b0, 18'o5000, 16'hA5A5);
    tick();
    check("t6_req", 32'(memREQO), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_req_async", 32'(memREQO), 32'd0);
    check("t6_busy_async", 32'(busy), 32'd0);
    devREQI = 1'b0;
    rst = 1'b1;
    tick();
    memACKI = 1'b1;
    tick();
    memACKI = 1'b0;
    check("t6_no_ack", 32'(devACKO), 32'd0);
    tick();
    check("t6_no_ack2", 32'(devACKO), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
